ram_arbiter: RTL and testbench

- Shares the single-port program/data RAM of the 16-bit CPU between two requesters: instruction fetch (read-only) and the data path (load/store).
- Sits between the control unit's fetch request and the execute stage's memory access on one side, and the RAM on the other.
- Serialises accesses with a small FSM, alternates priority round-robin on contention, and absorbs the RAM's configurable read latency behind a req/ack handshake.

---
 rtl/ram_arbiter.sv | 124 ++++++++++++
 tb/tb_ram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the CPU's single-port RAM: instruction fetch and data load/store.
// Round-robin on contention, hides the RAM read latency behind a req/ack handshake.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              last_grant
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    generate
        if (RD_LAT < 1 || RD_LAT > 7) begin : g_lat_check
            $error("ram_arbiter: RD_LAT must lie in 1..7");
        end
    endgenerate

    logic [1:0] state_r;
    logic [2:0] cnt_r;
    logic       req_any_s;
    logic       gnt_d_s;

    // Grant choice for the IDLE cycle: on a tie the port not served last wins.
    always_comb begin
        req_any_s = f_req | d_req;
        if (f_req && d_req) begin
            gnt_d_s = ~last_grant;
        end else if (d_req) begin
            gnt_d_s = 1'b1;
        end else begin
            gnt_d_s = 1'b0;
        end
    end

    // Access sequencer; last_grant doubles as the granted-port select until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 3'd0;
            ram_addr   <= {ADDR_W{1'b0}};
            ram_wdata  <= {DATA_W{1'b0}};
            ram_we     <= 1'b0;
            ram_re     <= 1'b0;
            f_ack      <= 1'b0;
            d_ack      <= 1'b0;
            f_rdata    <= {DATA_W{1'b0}};
            d_rdata    <= {DATA_W{1'b0}};
            busy       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            ram_we <= 1'b0;
            ram_re <= 1'b0;
            f_ack  <= 1'b0;
            d_ack  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        state_r    <= ST_ACCESS;
                        busy       <= 1'b1;
                        last_grant <= gnt_d_s;
                        ram_addr   <= gnt_d_s ? d_addr : f_addr;
                        ram_wdata  <= gnt_d_s ? d_wdata : {DATA_W{1'b0}};
                        ram_we     <= gnt_d_s & d_we;
                        ram_re     <= ~(gnt_d_s & d_we);
                    end
                end
                ST_ACCESS: begin
                    if (ram_we) begin
                        state_r <= ST_DONE;
                        f_ack   <= ~last_grant;
                        d_ack   <= last_grant;
                    end else begin
                        cnt_r   <= 3'(RD_LAT);
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 3'd1;
                    if (cnt_r == 3'd1) begin
                        state_r <= ST_DONE;
                        f_ack   <= ~last_grant;
                        d_ack   <= last_grant;
                        if (last_grant) begin
                            d_rdata <= ram_rdata;
                        end else begin
                            f_rdata <= ram_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: timeline model for the RD_LAT=2 instance plus directed checks,
// and two extra instances (RD_LAT=1, RD_LAT=7) for latency sweep checks.
module tb_ram_arbiter;

    localparam int LAT0 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [7:0]  f_addr = 8'h00;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = 8'h00;
    logic [15:0] d_wdata = 16'h0000;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [15:0] pl_data = 16'h0000;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
        logic        f_ack, d_ack, ram_we, ram_re, busy, last_grant;
        logic [15:0] f_rdata, d_rdata, ram_wdata, ram_rdata;
        logic [7:0]  ram_addr;
        logic [15:0] mem [256];
        logic [15:0] sh [8];

        ram_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
            .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_ack(d_ack), .d_rdata(d_rdata),
            .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
            .ram_re(ram_re), .ram_rdata(ram_rdata),
            .busy(busy), .last_grant(last_grant)
        );

        // RAM model: data is valid only in the cycle LAT cycles after ram_re, garbage otherwise
        always @(posedge clk) begin
            if (pl_en) mem[pl_addr] <= pl_data;
            else if (ram_we) mem[ram_addr] <= ram_wdata;
            sh[0] <= ram_re ? mem[ram_addr] : 16'hDEAD;
            for (int k = 1; k < 8; k++) sh[k] <= sh[k-1];
        end
        assign ram_rdata = sh[LAT-1];
    end

    wire        f_ack0 = g_inst[0].f_ack;
    wire        d_ack0 = g_inst[0].d_ack;
    wire        ram_we0 = g_inst[0].ram_we;
    wire        ram_re0 = g_inst[0].ram_re;
    wire        busy0 = g_inst[0].busy;
    wire        lg0 = g_inst[0].last_grant;
    wire [15:0] f_rdata0 = g_inst[0].f_rdata;
    wire [15:0] d_rdata0 = g_inst[0].d_rdata;
    wire [15:0] ram_wdata0 = g_inst[0].ram_wdata;
    wire [7:0]  ram_addr0 = g_inst[0].ram_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model of the RD_LAT=2 instance: each grant is a timeline (grant cycle, strobe cycle, ack cycle)
    bit          chk_en = 1'b0;
    int          g_cyc = -100;
    int          g_ack = -100;
    bit          g_port = 1'b1;
    bit          g_we = 1'b0;
    bit          prev_lg = 1'b1;
    logic [7:0]  g_addr = 8'h00;
    logic [15:0] g_wdata = 16'h0000;
    logic [15:0] g_rd = 16'h0000;
    logic [15:0] f_exp = 16'h0000;
    logic [15:0] d_exp = 16'h0000;
    logic [15:0] ref_mem [256];

    always @(negedge clk) begin
        bit e_busy, e_lg, port;
        e_busy = (cyc > g_cyc) && (cyc <= g_ack);
        e_lg = (cyc > g_cyc) ? g_port : prev_lg;
        if (cyc == g_ack && !g_we) begin
            if (g_port) d_exp = g_rd;
            else f_exp = g_rd;
        end
        if (chk_en) begin
            chk("m_busy", busy0, e_busy);
            chk("m_last_grant", lg0, e_lg);
            chk("m_ram_re", ram_re0, (cyc == g_cyc + 1) && !g_we);
            chk("m_ram_we", ram_we0, (cyc == g_cyc + 1) && g_we);
            chk("m_f_ack", f_ack0, (cyc == g_ack) && !g_port);
            chk("m_d_ack", d_ack0, (cyc == g_ack) && g_port);
            chk("m_f_rdata", f_rdata0, f_exp);
            chk("m_d_rdata", d_rdata0, d_exp);
            if (e_busy) chk("m_ram_addr", ram_addr0, g_addr);
            if (e_busy && g_we) chk("m_ram_wdata", ram_wdata0, g_wdata);
        end
        if (pl_en) ref_mem[pl_addr] = pl_data;
        if (rst) begin
            chk_en = 1'b1;
            g_cyc = -100;
            g_ack = -100;
            g_port = 1'b1;
            g_we = 1'b0;
            prev_lg = 1'b1;
            f_exp = 16'h0000;
            d_exp = 16'h0000;
        end else if (chk_en && cyc > g_ack && (f_req || d_req)) begin
            port = (f_req && d_req) ? ~e_lg : d_req;
            prev_lg = e_lg;
            g_port = port;
            g_we = port & d_we;
            g_cyc = cyc;
            g_addr = port ? d_addr : f_addr;
            g_wdata = d_wdata;
            g_ack = cyc + (g_we ? 2 : 2 + LAT0);
            if (g_we) ref_mem[g_addr] = g_wdata;
            else g_rd = ref_mem[g_addr];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        f_req = 1'b0;
        d_req = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick(1);
        pl_en = 1'b0;
    endtask

    // Waits for the port's ack (bounded), then drops that port's req at the edge ending the ack
    task automatic wait_ack(input bit port, input bit strict, output int at);
        at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (strict) chk(port ? "no f_ack while data pending" : "no d_ack while fetch pending",
                            port ? f_ack0 : d_ack0, 1'b0);
            if ((port ? d_ack0 : f_ack0) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk(port ? "d_ack timeout" : "f_ack timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (port) d_req = 1'b0;
        else f_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, at, a0, a1, a2, prev;
        do_reset();
        @(negedge clk);
        chk("reset busy", busy0, 1'b0);
        chk("reset last_grant", lg0, 1'b1);
        chk("reset f_ack", f_ack0, 1'b0);
        chk("reset ram_re", ram_re0, 1'b0);
        chk("reset ram_we", ram_we0, 1'b0);
        chk("reset ram_addr", ram_addr0, 8'h00);
        chk("reset f_rdata", f_rdata0, 16'h0000);
        @(posedge clk);
        #1;
        preload(8'h10, 16'hA5C3);
        preload(8'h30, 16'hBEEF);

        // 1: fetch with RD_LAT=2
        f_addr = 8'h10;
        f_req = 1'b1;
        t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        chk("t1 ram_re", ram_re0, 1'b1);
        chk("t1 ram_addr", ram_addr0, 8'h10);
        wait_ack(1'b0, 1'b1, at);
        chk("t1 f_ack cycle", at - t0, 32'd4);
        chk("t1 f_rdata", f_rdata0, 16'hA5C3);

        // 2: store then load back
        d_we = 1'b1;
        d_addr = 8'h20;
        d_wdata = 16'h1234;
        d_req = 1'b1;
        t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        chk("t2 ram_we", ram_we0, 1'b1);
        chk("t2 ram_addr", ram_addr0, 8'h20);
        chk("t2 ram_wdata", ram_wdata0, 16'h1234);
        wait_ack(1'b1, 1'b1, at);
        chk("t2 d_ack cycle", at - t0, 32'd2);
        d_we = 1'b0;
        d_req = 1'b1;
        t0 = cyc;
        wait_ack(1'b1, 1'b1, at);
        chk("t2 load ack cycle", at - t0, 32'd4);
        chk("t2 d_rdata", d_rdata0, 16'h1234);

        // 3: simultaneous requests after reset, fetch first twice
        do_reset();
        f_req = 1'b1;
        d_req = 1'b1;
        wait_ack(1'b0, 1'b1, at);
        chk("t3 last_grant after fetch", lg0, 1'b0);
        wait_ack(1'b1, 1'b1, at);
        chk("t3 last_grant after data", lg0, 1'b1);
        chk("t3 d_rdata", d_rdata0, 16'h1234);
        f_req = 1'b1;
        d_req = 1'b1;
        wait_ack(1'b0, 1'b1, at);
        wait_ack(1'b1, 1'b1, at);

        // 4: both held for 8 grants, strict alternation, 5-cycle spacing for reads
        f_req = 1'b1;
        d_req = 1'b1;
        a0 = 0;
        prev = -1;
        for (int i = 0; i < 100 && a0 < 8; i++) begin
            @(negedge clk);
            if (f_ack0 || d_ack0) begin
                chk("t4 grant order", d_ack0, a0 % 2);
                if (prev >= 0) chk("t4 ack spacing", cyc - prev, 32'd5);
                prev = cyc;
                a0++;
            end
        end
        chk("t4 grants seen", a0, 32'd8);
        @(posedge clk);
        #1;
        f_req = 1'b0;
        d_req = 1'b0;
        tick(2);

        // 5: reset during WAIT of a load
        do_reset();
        d_we = 1'b0;
        d_addr = 8'h30;
        d_req = 1'b1;
        tick(2);
        rst = 1'b1;
        d_req = 1'b0;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t5 busy", busy0, 1'b0);
        chk("t5 ram_re", ram_re0, 1'b0);
        chk("t5 d_ack", d_ack0, 1'b0);
        chk("t5 d_rdata", d_rdata0, 16'h0000);
        repeat (4) begin
            @(negedge clk);
            chk("t5 no late d_ack", d_ack0, 1'b0);
        end
        @(posedge clk);
        #1;
        f_addr = 8'h10;
        f_req = 1'b1;
        t0 = cyc;
        wait_ack(1'b0, 1'b1, at);
        chk("t5 fetch ack cycle", at - t0, 32'd4);
        chk("t5 f_rdata", f_rdata0, 16'hA5C3);

        // 6: latency sweep across the three instances
        do_reset();
        f_addr = 8'h10;
        f_req = 1'b1;
        t0 = cyc;
        tick(1);
        f_req = 1'b0;
        a0 = -1; a1 = -1; a2 = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (a0 < 0 && f_ack0) a0 = cyc;
            if (a1 < 0 && g_inst[1].f_ack) a1 = cyc;
            if (a2 < 0 && g_inst[2].f_ack) a2 = cyc;
        end
        chk("t6 lat2 read ack", a0 - t0, 32'd4);
        chk("t6 lat1 read ack", a1 - t0, 32'd3);
        chk("t6 lat7 read ack", a2 - t0, 32'd9);
        chk("t6 lat1 f_rdata", g_inst[1].f_rdata, 16'hA5C3);
        chk("t6 lat7 f_rdata", g_inst[2].f_rdata, 16'hA5C3);
        @(posedge clk);
        #1;
        d_we = 1'b1;
        d_addr = 8'h40;
        d_wdata = 16'h5A5A;
        d_req = 1'b1;
        t0 = cyc;
        tick(1);
        d_req = 1'b0;
        a0 = -1; a1 = -1; a2 = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a0 < 0 && d_ack0) a0 = cyc;
            if (a1 < 0 && g_inst[1].d_ack) a1 = cyc;
            if (a2 < 0 && g_inst[2].d_ack) a2 = cyc;
        end
        chk("t6 lat2 write ack", a0 - t0, 32'd2);
        chk("t6 lat1 write ack", a1 - t0, 32'd2);
        chk("t6 lat7 write ack", a2 - t0, 32'd2);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
